// File: rtl/fluid_pkg.sv
// Types and constants shared by the D2Q9 lattice-Boltzmann sweep blocks.
package fluid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } sweep_state_t;

  localparam int NUM_DIRS = 9;

  localparam int DIR_C  = 0;
  localparam int DIR_N  = 1;
  localparam int DIR_NE = 2;
  localparam int DIR_E  = 3;
  localparam int DIR_SE = 4;
  localparam int DIR_S  = 5;
  localparam int DIR_SW = 6;
  localparam int DIR_W  = 7;
  localparam int DIR_NW = 8;

  // Counter width that stays legal for a size of 1.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lattice_sweep_ctrl_pipe.sv
// Fixed-depth pipeline delay line with synchronous active-low clear.
// Every stage is a register, so the output is registered.
module lattice_sweep_ctrl_pipe #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = d_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/lattice_sweep_ctrl.sv
// Per-timestep raster sweep controller for the D2Q9 LBM core, with delayed
// writeback coordinates and ping-pong buffer select. FLUID_STALL_EN enables stall_in.
module lattice_sweep_ctrl
  import fluid_pkg::*;
#(
  parameter int  HPIXELS     = 64,
  parameter int  VPIXELS     = 48,
  parameter int  LATENCY     = 3,
  parameter int  COLLIDE_LAT = 4,
  localparam int HOR_SIZE    = clog2_min1(HPIXELS),
  localparam int VERT_SIZE   = clog2_min1(VPIXELS),
  localparam int WR_LAT      = LATENCY + COLLIDE_LAT
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start_in,
  input  logic                                stall_in,
  output logic                                busy_out,
  output logic                                done_out,
  output logic [NUM_DIRS-1:0][HOR_SIZE-1:0]   hor_out,
  output logic [NUM_DIRS-1:0][VERT_SIZE-1:0]  vert_out,
  output logic                                rd_valid_out,
  output logic                                wr_valid_out,
  output logic [HOR_SIZE-1:0]                 wr_hor_out,
  output logic [VERT_SIZE-1:0]                wr_vert_out,
  output logic                                buf_sel_out
);

  localparam int DRAIN_W  = clog2_min1(WR_LAT);
  localparam int PIPE_W   = 1 + HOR_SIZE + VERT_SIZE;

  sweep_state_t         state_q, state_d;
  logic [HOR_SIZE-1:0]  hor_q, hor_d;
  logic [VERT_SIZE-1:0] vert_q, vert_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 buf_sel_q, buf_sel_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 stall_eff;
  logic                 last_hor;
  logic                 last_vert;

`ifdef FLUID_STALL_EN
  assign stall_eff = stall_in;
`else
  logic unused_stall;
  assign unused_stall = stall_in;
  assign stall_eff    = 1'b0;
`endif

  // Wrap by comparison so non-power-of-two lattice sizes work.
  assign last_hor  = (hor_q == HOR_SIZE'(HPIXELS - 1));
  assign last_vert = (vert_q == VERT_SIZE'(VPIXELS - 1));

  always_comb begin
    state_d     = state_q;
    hor_d       = hor_q;
    vert_d      = vert_q;
    rd_valid_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    buf_sel_d   = buf_sel_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d    = SWEEP;
          hor_d      = '0;
          vert_d     = '0;
          rd_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SWEEP: begin
        // The presented coordinate has already been read; a stall just holds it.
        if (!stall_eff) begin
          if (last_hor && last_vert) begin
            state_d     = DRAIN;
            hor_d       = '0;
            vert_d      = '0;
            drain_cnt_d = '0;
          end else if (last_hor) begin
            hor_d      = '0;
            vert_d     = vert_q + VERT_SIZE'(1);
            rd_valid_d = 1'b1;
          end else begin
            hor_d      = hor_q + HOR_SIZE'(1);
            rd_valid_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // done_out is raised in the final DRAIN cycle so a start there is refused.
        if (done_q) begin
          state_d = IDLE;
        end else if (drain_cnt_q == DRAIN_W'(WR_LAT - 1)) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          buf_sel_d = ~buf_sel_q;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      hor_q       <= '0;
      vert_q      <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      buf_sel_q   <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hor_q       <= hor_d;
      vert_q      <= vert_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      buf_sel_q   <= buf_sel_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  generate
    for (genvar gi = DIR_C; gi <= DIR_NW; gi++) begin : g_lane
      assign hor_out[gi]  = hor_q;
      assign vert_out[gi] = vert_q;
    end
  endgenerate

  lattice_sweep_ctrl_pipe #(
    .DEPTH (WR_LAT),
    .WIDTH (PIPE_W)
  ) u_wr_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   ({rd_valid_q, hor_q, vert_q}),
    .q_out  ({wr_valid_out, wr_hor_out, wr_vert_out})
  );

  assign rd_valid_out = rd_valid_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign buf_sel_out  = buf_sel_q;

endmodule
